// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter for the 64-bit Avalon-MM SDRAM port: scanout (port 0) has priority over draw (port 1).
// Optional `define ARB_STARVE_GUARD_EN bounds how long port 0 may keep winning while port 1 waits.
module sdram_port_arbiter #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int STARVE_LIMIT    = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [28:0] m0_address,
   input  logic        m0_read,
   output logic        m0_waitrequest,
   output logic [63:0] m0_readdata,
   output logic        m0_readdatavalid,
   input  logic [28:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [63:0] m1_writedata,
   input  logic [7:0]  m1_byteenable,
   output logic        m1_waitrequest,
   output logic [63:0] m1_readdata,
   output logic        m1_readdatavalid,
   output logic [28:0] avm_address,
   output logic [7:0]  avm_burstcount,
   output logic        avm_read,
   output logic        avm_write,
   output logic [63:0] avm_writedata,
   output logic [7:0]  avm_byteenable,
   input  logic        avm_waitrequest,
   input  logic [63:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic [1:0]  grant,
   output logic [4:0]  outstanding,
   output logic        err_orphan
);

   localparam int IDX_W = $clog2(MAX_OUTSTANDING);
   // An out-of-range configuration blocks all reads rather than overflowing the tag FIFO.
   localparam bit CFG_OK = (MAX_OUTSTANDING >= 2) && (MAX_OUTSTANDING <= 16) &&
                           (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   state_t state, state_nxt;

   logic             rd_free, p0_elig, p1_elig, p1_req, starve_hit;
   logic             avm_cmd, push, ret_vld, head;
   logic [IDX_W-1:0] push_pos;
   logic             tags [MAX_OUTSTANDING];

   assign rd_free = CFG_OK && (outstanding < 5'(MAX_OUTSTANDING));
   assign p0_elig = m0_read & rd_free;
   assign p1_elig = m1_write | (m1_read & rd_free);
   assign p1_req  = m1_read | m1_write;

`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt;
   assign starve_hit = (starve_cnt >= 4'(STARVE_LIMIT));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         starve_cnt <= 4'd0;
      else if (state == IDLE) begin
         if (!p1_req || state_nxt == OWN1)
            starve_cnt <= 4'd0;
         else if (state_nxt == OWN0 && starve_cnt != 4'hF)
            starve_cnt <= starve_cnt + 4'd1;
      end
   end
`else
   assign starve_hit = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Owner leaves on acceptance, or immediately if it abandons its request.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (p1_elig && starve_hit)
               state_nxt = OWN1;
            else if (p0_elig)
               state_nxt = OWN0;
            else if (p1_elig)
               state_nxt = OWN1;
         end
         OWN0, OWN1: begin
            if (!avm_cmd || !avm_waitrequest)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      avm_address    = '0;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      avm_writedata  = '0;
      avm_byteenable = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      case (state)
         OWN0: begin
            avm_address    = m0_address;
            avm_read       = m0_read;
            avm_byteenable = 8'hFF;
            m0_waitrequest = avm_waitrequest;
         end
         OWN1: begin
            avm_address    = m1_address;
            avm_write      = m1_write;
            avm_read       = m1_read & ~m1_write;
            avm_writedata  = m1_writedata;
            avm_byteenable = m1_byteenable;
            m1_waitrequest = avm_waitrequest;
         end
         default: ;
      endcase
   end

   assign avm_burstcount = 8'h01;
   assign avm_cmd        = avm_read | avm_write;
   assign grant          = {state == OWN1, state == OWN0};

   assign push     = avm_read & ~avm_waitrequest;
   assign ret_vld  = avm_readdatavalid & (outstanding != 5'd0);
   assign head     = tags[0];
   assign push_pos = IDX_W'(ret_vld ? outstanding - 5'd1 : outstanding);

   assign m0_readdata      = avm_readdata;
   assign m1_readdata      = avm_readdata;
   assign m0_readdatavalid = ret_vld & ~head;
   assign m1_readdatavalid = ret_vld & head;

   // Shift-register tag FIFO: entry 0 is always the oldest read in flight.
   always_ff @(posedge clock) begin
      if (ret_vld)
         for (int i = 0; i < MAX_OUTSTANDING - 1; i++)
            tags[i] <= tags[i+1];
      if (push)
         tags[push_pos] <= (state == OWN1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         outstanding <= 5'd0;
         err_orphan  <= 1'b0;
      end else begin
         if (push && !ret_vld)
            outstanding <= outstanding + 5'd1;
         else if (!push && ret_vld)
            outstanding <= outstanding - 5'd1;
         if (avm_readdatavalid && outstanding == 5'd0)
            err_orphan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios, then random traffic against a queue-based reference model.
module tb_sdram_port_arbiter;

   localparam int MAXO = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [28:0] m0_address, m1_address, avm_address;
   logic        m0_read, m0_waitrequest, m0_readdatavalid;
   logic [63:0] m0_readdata, m1_readdata, m1_writedata, avm_writedata, avm_readdata;
   logic        m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
   logic [7:0]  m1_byteenable, avm_burstcount, avm_byteenable;
   logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
   logic [1:0]  grant;
   logic [4:0]  outstanding;
   logic        err_orphan;

   sdram_port_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_read(avm_read),
      .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .grant(grant), .outstanding(outstanding), .err_orphan(err_orphan)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [28:0] addr;
      int          port;
   } rd_t;

   rd_t         sq[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   bit          a0, a1, w1, rv, acc0, acc1;
   logic [28:0] ad0, ad1;
   logic [63:0] wd1;
   logic [7:0]  be1;
   int          ngrant, nbad;
   logic [1:0]  grant9;

   function automatic logic [63:0] dfn(input logic [28:0] a);
      return {3'b101, a, 3'b011, ~a};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input int port, input bit wr, input logic [28:0] addr,
                        input logic [63:0] wd, input logic [7:0] be);
      bit done = 1'b0;
      if (port == 0) begin
         m0_read = 1'b1; m0_address = addr;
      end else begin
         m1_read = !wr; m1_write = wr; m1_address = addr; m1_writedata = wd; m1_byteenable = be;
      end
      for (int i = 0; i < 20 && !done; i++) begin
         #2;
         if ((port == 0) ? !m0_waitrequest : !m1_waitrequest) done = 1'b1;
         tick();
      end
      m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
      check("issue_accepted", done, 1);
   endtask

   task automatic ret(input logic [63:0] d, input int port);
      avm_readdatavalid = 1'b1;
      avm_readdata      = d;
      #2;
      check("ret_route", {m0_readdatavalid, m1_readdatavalid}, (port == 0) ? 2'b10 : 2'b01);
      check("ret_data", (port == 0) ? m0_readdata : m1_readdata, d);
      tick();
      avm_readdatavalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      m0_address = '0; m0_read = 0; m1_address = '0; m1_read = 0; m1_write = 0;
      m1_writedata = '0; m1_byteenable = '0;
      avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0;
      #12;
      check("rst_grant", grant, 2'b00);
      check("rst_outstanding", outstanding, 0);
      check("rst_err_orphan", err_orphan, 0);
      check("rst_avm_cmd", {avm_read, avm_write}, 2'b00);
      check("rst_waitrequest", {m0_waitrequest, m1_waitrequest}, 2'b11);
      check("rst_rdvalid", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
      tick();
      reset_n = 1'b1;
      tick();

      // single port-0 read, return two cycles after acceptance
      m0_read = 1; m0_address = 29'h0700_0000;
      #2;
      check("t1_bubble", {grant, avm_read, m0_waitrequest}, {2'b00, 1'b0, 1'b1});
      tick();
      #2;
      check("t1_grant", grant, 2'b01);
      check("t1_cmd", {avm_read, avm_write, avm_address, avm_byteenable, avm_burstcount, m0_waitrequest},
            {1'b1, 1'b0, 29'h0700_0000, 8'hFF, 8'h01, 1'b0});
      check("t1_out0", outstanding, 0);
      tick();
      m0_read = 0;
      #2;
      check("t1_out1", {grant, outstanding}, {2'b00, 5'd1});
      tick();
      ret(64'hA5A5_0000_FFFF_1234, 0);
      #2;
      check("t1_out_back", outstanding, 0);
      tick();

      // simultaneous port-0 read and port-1 write
      m0_read = 1; m0_address = 29'h0123_4567;
      m1_write = 1; m1_address = 29'h0700_0001; m1_writedata = 64'hFFFF_FFFF_FFFF_FFFF; m1_byteenable = 8'h0F;
      tick();
      #2;
      check("t2_p0_first", {grant, avm_read, avm_address, m0_waitrequest, m1_waitrequest},
            {2'b01, 1'b1, 29'h0123_4567, 1'b0, 1'b1});
      tick();
      m0_read = 0;
      #2;
      check("t2_bubble", {grant, m1_waitrequest}, {2'b00, 1'b1});
      tick();
      #2;
      check("t2_write", {grant, avm_read, avm_write, avm_address, avm_byteenable, m1_waitrequest},
            {2'b10, 1'b0, 1'b1, 29'h0700_0001, 8'h0F, 1'b0});
      check("t2_wdata", avm_writedata, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      m1_write = 0;
      ret(64'h1111_2222_3333_4444, 0);

      // interleaved reads 0,1,0 then in-order returns
      issue(0, 0, 29'h10, '0, '0);
      issue(1, 0, 29'h20, '0, 8'hFF);
      issue(0, 0, 29'h30, '0, '0);
      #2;
      check("t3_out3", outstanding, 3);
      ret(64'hD0D0_D0D0_0000_0000, 0);
      ret(64'hD1D1_D1D1_1111_1111, 1);
      ret(64'hD2D2_D2D2_2222_2222, 0);

      // tag FIFO full
      for (int i = 0; i < MAXO; i++) issue(0, 0, 29'(i), '0, '0);
      #2;
      check("t4_full", outstanding, MAXO);
      m0_read = 1; m0_address = 29'h55;
      tick();
      for (int i = 0; i < 3; i++) begin
         #2;
         check("t4_blocked", {grant, m0_waitrequest}, {2'b00, 1'b1});
         tick();
      end
      m1_write = 1; m1_address = 29'h66; m1_writedata = 64'h0123_4567_89AB_CDEF; m1_byteenable = 8'hF0;
      #2;
      check("t4_idle", grant, 2'b00);
      tick();
      #2;
      check("t4_write_granted", {grant, avm_write, m1_waitrequest, m0_waitrequest}, {2'b10, 1'b1, 1'b0, 1'b1});
      tick();
      m1_write = 0;
      #2;
      check("t4_still_blocked", grant, 2'b00);
      tick();
      ret(64'hAAAA_0000_0000_0001, 0);
      #2;
      check("t4_decide", {grant, outstanding}, {2'b00, 5'd3});
      tick();
      #2;
      check("t4_pending_granted", {grant, avm_read, avm_address, m0_waitrequest}, {2'b01, 1'b1, 29'h55, 1'b0});
      tick();
      m0_read = 0;
      #2;
      check("t4_refull", outstanding, MAXO);
      for (int i = 0; i < MAXO; i++) ret(64'(i) + 64'hBB00, 0);

      // accept and return in the same cycle
      issue(0, 0, 29'h77, '0, '0);
      m1_read = 1; m1_address = 29'h88;
      tick();
      avm_readdatavalid = 1; avm_readdata = 64'hCAFE_F00D_0000_0077;
      #2;
      check("t5_accept", {grant, m1_waitrequest}, {2'b10, 1'b0});
      check("t5_route", {m0_readdatavalid, m1_readdatavalid, m0_readdata}, {2'b10, 64'hCAFE_F00D_0000_0077});
      tick();
      m1_read = 0; avm_readdatavalid = 0;
      #2;
      check("t5_out_same", outstanding, 1);
      tick();
      ret(64'hCAFE_F00D_0000_0088, 1);

      // orphan return, then asynchronous reset
      #2;
      check("t6_empty", outstanding, 0);
      avm_readdatavalid = 1; avm_readdata = 64'hDEAD;
      #1;
      check("t6_no_valid", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
      tick();
      avm_readdatavalid = 0;
      #2;
      check("t6_err_orphan", err_orphan, 1);
      reset_n = 0;
      #1;
      check("t6_async_reset", {err_orphan, grant, outstanding}, 8'h00);
      tick();
      reset_n = 1;
      tick();

      // continuous requests from both ports: who wins the 9th decision
      m0_read = 1; m0_address = 29'h9; m1_read = 1; m1_address = 29'hA;
      ngrant = 0; nbad = 0; grant9 = 2'b00;
      for (int i = 0; i < 60 && ngrant < 9; i++) begin
         avm_readdatavalid = (outstanding != 0);
         avm_readdata = 64'h5;
         #2;
         if (grant != 2'b00) begin
            ngrant++;
            if (ngrant == 9) grant9 = grant;
            else if (grant != 2'b01) nbad++;
         end
         tick();
      end
      m0_read = 0; m1_read = 0;
      check("t7_nine_decisions", ngrant, 9);
      check("t7_first_eight_p0", nbad, 0);
`ifdef ARB_STARVE_GUARD_EN
      check("t7_ninth", grant9, 2'b10);
`else
      check("t7_ninth", grant9, 2'b01);
`endif
      for (int i = 0; i < 20 && outstanding != 0; i++) begin
         avm_readdatavalid = 1;
         tick();
      end
      avm_readdatavalid = 0;
      #2;
      check("t7_drained", {outstanding, err_orphan}, 6'd0);
      tick();

      // random traffic against the reference model
      a0 = 0; a1 = 0; w1 = 0; ad0 = '0; ad1 = '0; wd1 = '0; be1 = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (!a0 && $urandom_range(2) == 0) begin a0 = 1; ad0 = 29'($urandom); end
         if (!a1 && $urandom_range(2) == 0) begin
            a1 = 1; w1 = 1'($urandom_range(1)); ad1 = 29'($urandom);
            wd1 = {$urandom, $urandom}; be1 = 8'($urandom);
         end
         m0_read = a0; m0_address = ad0;
         m1_read = a1 && !w1; m1_write = a1 && w1;
         m1_address = ad1; m1_writedata = wd1; m1_byteenable = be1;
         avm_waitrequest = ($urandom_range(3) == 0);
         rv = (sq.size() > 0) && ($urandom_range(1) == 1);
         avm_readdatavalid = rv;
         avm_readdata = rv ? dfn(sq[0].addr) : {$urandom, $urandom};
         #2;
         check("rnd_outstanding", outstanding, sq.size());
         check("rnd_grant_legal", (grant != 2'b11), 1);
         if (rv) begin
            check("rnd_route", {m0_readdatavalid, m1_readdatavalid}, (sq[0].port == 0) ? 2'b10 : 2'b01);
            check("rnd_rdata", (sq[0].port == 0) ? m0_readdata : m1_readdata, dfn(sq[0].addr));
         end else
            check("rnd_no_valid", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
         acc0 = m0_read && !m0_waitrequest;
         acc1 = (m1_read || m1_write) && !m1_waitrequest;
         check("rnd_accept_map", (avm_read | avm_write) & ~avm_waitrequest, acc0 | acc1);
         if (acc0)
            check("rnd_cmd0", {avm_read, avm_write, avm_address, avm_byteenable}, {2'b10, ad0, 8'hFF});
         if (acc1) begin
            check("rnd_cmd1", {avm_read, avm_write, avm_address, avm_byteenable}, {!w1, w1, ad1, be1});
            if (w1) check("rnd_wdata", avm_writedata, wd1);
         end
         if (acc0 || (acc1 && !w1)) check("rnd_not_full", sq.size() < MAXO, 1);
         tick();
         if (rv) void'(sq.pop_front());
         if (acc0) begin sq.push_back('{addr: ad0, port: 0}); a0 = 0; end
         if (acc1) begin
            if (!w1) sq.push_back('{addr: ad1, port: 1});
            a1 = 0;
         end
      end
      m0_read = 0; m1_read = 0; m1_write = 0; avm_waitrequest = 0;
      while (sq.size() > 0) begin
         ret(dfn(sq[0].addr), sq[0].port);
         void'(sq.pop_front());
      end
      #2;
      check("end_idle", {grant, outstanding, err_orphan}, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
